rx_trig_deframer: RTL and testbench

- Per-lane receive stage. Sits directly downstream of one Aurora streaming RX lane and consumes its rx_d / rx_src_rdy_n words in the user_clk domain.
- Hunts for trigger-frame headers, collects a fixed-length payload and verifies an XOR checksum trailer.
- Presents each good frame as one wide word on a valid/ready interface, with saturating error/gap/overflow statistics.
- The Aurora stream has no backpressure, so frames that cannot be delivered are dropped and counted.

---
 rtl/rx_trig_deframer.sv | 181 ++++++++++++++++++
 tb/tb_rx_trig_deframer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_trig_deframer.sv
// rx_trig_deframer
// Per-lane receive stage behind one Aurora streaming RX lane.
// - Hunts for trigger-frame headers.
// - Collects PAYLOAD_WORDS payload words.
// - Checks an XOR checksum trailer.
// - Presents each good frame as one wide word on a valid/ready interface.
// The lane has no backpressure, so a good frame that cannot be delivered is
// dropped and counted.
//
// Ports:
//   user_clk       lane user clock, all logic on rising edge
//   reset_n        synchronous active-low reset
//   channel_up     Aurora channel status, low forces resynchronisation
//   rx_d           received word
//   rx_src_rdy_n   active-low word valid
//   trig_data      frame payload, word k at [32k+31:32k]
//   trig_seq       header bits [15:0] of the delivered frame
//   trig_valid     frame available
//   trig_ready     consumer accepts the frame
//   in_frame       high while collecting payload/trailer
//   frame_err_cnt  checksum failures (saturating)
//   seq_gap_cnt    sequence discontinuities (saturating)
//   overflow_cnt   good frames dropped because output was occupied (saturating)
//
// state   | meaning
// --------+----------------------------------------------------
// HUNT    | discard words until one carries HEADER_MAGIC
// PAYLOAD | store payload words, accumulate checksum
// TRAILER | compare next word against checksum, then back to HUNT

module rx_trig_deframer #(
    parameter int          PAYLOAD_WORDS = 4,
    parameter logic [15:0] HEADER_MAGIC  = 16'hBE11,
    parameter int          CNT_W         = 16
) (
    input  logic                       user_clk,
    input  logic                       reset_n,
    input  logic                       channel_up,
    input  logic [31:0]                rx_d,
    input  logic                       rx_src_rdy_n,
    output logic [32*PAYLOAD_WORDS-1:0] trig_data,
    output logic [15:0]                trig_seq,
    output logic                       trig_valid,
    input  logic                       trig_ready,
    output logic                       in_frame,
    output logic [CNT_W-1:0]           frame_err_cnt,
    output logic [CNT_W-1:0]           seq_gap_cnt,
    output logic [CNT_W-1:0]           overflow_cnt
);

    localparam int IDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_WORDS - 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [31:0]      csum;
    logic [15:0]      seq;
    logic [31:0]      pbuf [PAYLOAD_WORDS];
    logic [15:0]      last_seq;
    logic             seq_known;

    logic acc;
    logic hdr_hit;
    logic frame_good;
    logic frame_bad;
    logic load_ok;
    logic seq_gap;

    assign acc     = !rx_src_rdy_n && channel_up;
    // The output register can take a new frame if it is empty or being
    // emptied on this very edge.
    assign load_ok = !trig_valid || trig_ready;
    assign seq_gap = frame_good && seq_known && (seq != 16'(last_seq + 16'd1));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        state_nx   = state;
        hdr_hit    = 1'b0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (!channel_up) begin
            state_nx = HUNT;
        end else if (acc) begin
            case (state)
                HUNT: begin
                    if (rx_d[31:16] == HEADER_MAGIC) begin
                        hdr_hit  = 1'b1;
                        state_nx = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (idx == LAST_IDX) begin
                        state_nx = TRAILER;
                    end
                end
                TRAILER: begin
                    state_nx = HUNT;
                    if (rx_d == csum) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            state         <= HUNT;
            idx           <= '0;
            csum          <= '0;
            seq           <= '0;
            for (int k = 0; k < PAYLOAD_WORDS; k++) begin
                pbuf[k] <= '0;
            end
            last_seq      <= '0;
            seq_known     <= 1'b0;
            trig_data     <= '0;
            trig_seq      <= '0;
            trig_valid    <= 1'b0;
            in_frame      <= 1'b0;
            frame_err_cnt <= '0;
            seq_gap_cnt   <= '0;
            overflow_cnt  <= '0;
        end else begin
            state    <= state_nx;
            in_frame <= (state_nx == PAYLOAD) || (state_nx == TRAILER);

            if (hdr_hit) begin
                seq  <= rx_d[15:0];
                csum <= rx_d;
                idx  <= '0;
            end else if (acc && state == PAYLOAD) begin
                pbuf[idx] <= rx_d;
                csum      <= csum ^ rx_d;
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
            end

            if (frame_good && load_ok) begin
                for (int k = 0; k < PAYLOAD_WORDS; k++) begin
                    trig_data[32*k +: 32] <= pbuf[k];
                end
                trig_seq   <= seq;
                trig_valid <= 1'b1;
            end else if (trig_valid && trig_ready) begin
                trig_valid <= 1'b0;
            end

            // Sequence tracking covers dropped good frames too.
            if (frame_good) begin
                last_seq  <= seq;
                seq_known <= 1'b1;
            end

            if (frame_bad) begin
                frame_err_cnt <= sat_inc(frame_err_cnt);
            end
            if (seq_gap) begin
                seq_gap_cnt <= sat_inc(seq_gap_cnt);
            end
            if (frame_good && !load_ok) begin
                overflow_cnt <= sat_inc(overflow_cnt);
            end
        end
    end

endmodule

// File: tb/tb_rx_trig_deframer.sv
// Testbench for rx_trig_deframer.
// Drives directed frame sequences and queues each frame expected at the
// output. Frames are popped from the queue and compared when the DUT
// presents them. Counter expectations come from a small sequence/overflow
// model kept alongside the stimulus.
// Ports: none (top-level bench).

module tb_rx_trig_deframer;

    localparam int PW = 4;

    logic            user_clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            channel_up = 1'b1;
    logic [31:0]     rx_d = '0;
    logic            rx_src_rdy_n = 1'b1;
    logic            trig_ready = 1'b0;
    logic [32*PW-1:0] trig_data;
    logic [15:0]     trig_seq;
    logic            trig_valid;
    logic            in_frame;
    logic [15:0]     frame_err_cnt;
    logic [15:0]     seq_gap_cnt;
    logic [15:0]     overflow_cnt;

    rx_trig_deframer #(
        .PAYLOAD_WORDS(PW),
        .HEADER_MAGIC (16'hBE11),
        .CNT_W        (16)
    ) dut (
        .user_clk     (user_clk),
        .reset_n      (reset_n),
        .channel_up   (channel_up),
        .rx_d         (rx_d),
        .rx_src_rdy_n (rx_src_rdy_n),
        .trig_data    (trig_data),
        .trig_seq     (trig_seq),
        .trig_valid   (trig_valid),
        .trig_ready   (trig_ready),
        .in_frame     (in_frame),
        .frame_err_cnt(frame_err_cnt),
        .seq_gap_cnt  (seq_gap_cnt),
        .overflow_cnt (overflow_cnt)
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic [32*PW-1:0] data;
        logic [15:0]      seq;
    } frame_t;

    frame_t sb[$];

    int total  = 0;
    int passes = 0;

    logic [31:0]      cur_csum;
    logic [15:0]      cur_seq;
    logic [32*PW-1:0] cur_data;
    logic             m_known;
    logic [15:0]      m_last;
    int               exp_err;
    int               exp_gap;
    int               exp_ovf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic word(input logic [31:0] w, input int idle);
        for (int i = 0; i < idle; i++) begin
            rx_src_rdy_n = 1'b1;
            @(negedge user_clk);
        end
        rx_d         = w;
        rx_src_rdy_n = 1'b0;
        @(negedge user_clk);
        rx_src_rdy_n = 1'b1;
    endtask

    task automatic body(input logic [15:0] s, input logic [31:0] base, input int idle);
        logic [31:0] w;
        cur_seq  = s;
        cur_csum = {16'hBE11, s};
        cur_data = '0;
        word(cur_csum, idle);
        chk("in_frame after header", in_frame, 1'b1);
        for (int k = 0; k < PW; k++) begin
            w = base + 32'(k + 1);
            cur_data[32*k +: 32] = w;
            cur_csum = cur_csum ^ w;
            word(w, idle);
        end
    endtask

    task automatic trailer(input logic good, input logic deliver, input int idle);
        frame_t f;
        word(good ? cur_csum : (cur_csum ^ 32'h1), idle);
        chk("in_frame after trailer", in_frame, 1'b0);
        if (good) begin
            if (m_known && cur_seq != 16'(m_last + 16'd1)) exp_gap++;
            m_last  = cur_seq;
            m_known = 1'b1;
            if (deliver) begin
                f.data = cur_data;
                f.seq  = cur_seq;
                sb.push_back(f);
            end else begin
                exp_ovf++;
            end
        end else begin
            exp_err++;
        end
    endtask

    task automatic expect_frame(input string tag, input logic consume);
        frame_t f;
        int n = 0;
        while (!trig_valid && n < 20) begin
            @(negedge user_clk);
            n++;
        end
        chk({tag, " valid"}, trig_valid, 1'b1);
        if (trig_valid) begin
            chk({tag, " pending"}, 128'(sb.size() > 0), 128'(1));
            if (sb.size() > 0) begin
                f = sb.pop_front();
                chk({tag, " data"}, trig_data, f.data);
                chk({tag, " seq"}, trig_seq, f.seq);
            end
            if (consume) begin
                if (!trig_ready) begin
                    trig_ready = 1'b1;
                    @(negedge user_clk);
                    trig_ready = 1'b0;
                end else begin
                    @(negedge user_clk);
                end
                chk({tag, " cleared"}, trig_valid, 1'b0);
            end
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, " err_cnt"}, frame_err_cnt, 16'(exp_err));
        chk({tag, " gap_cnt"}, seq_gap_cnt, 16'(exp_gap));
        chk({tag, " ovf_cnt"}, overflow_cnt, 16'(exp_ovf));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge user_clk);
        reset_n = 1'b1;
        m_known = 1'b0;
        m_last  = '0;
        exp_err = 0;
        exp_gap = 0;
        exp_ovf = 0;
        sb.delete();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " valid"}, trig_valid, 1'b0);
        chk({tag, " data"}, trig_data, '0);
        chk({tag, " seq"}, trig_seq, 16'h0);
        chk({tag, " in_frame"}, in_frame, 1'b0);
        check_counters(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_known = 1'b0;
        m_last  = '0;
        exp_err = 0;
        exp_gap = 0;
        exp_ovf = 0;
        repeat (2) @(negedge user_clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge user_clk);

        // Basic frame: BE110005, 1..4, trailer BE110001.
        body(16'h0005, 32'h0, 0);
        chk("basic trailer word", cur_csum, 32'hBE11_0001);
        trailer(1'b1, 1'b1, 0);
        chk("basic latency valid", trig_valid, 1'b1);
        chk("basic data const", trig_data,
            128'h00000004_00000003_00000002_00000001);
        expect_frame("basic", 1'b1);
        check_counters("basic");

        // Bad checksum, then good frame with seq 6.
        body(16'h0005, 32'h0, 0);
        trailer(1'b0, 1'b1, 0);
        chk("bad valid", trig_valid, 1'b0);
        check_counters("bad");
        body(16'h0006, 32'h0, 0);
        trailer(1'b1, 1'b1, 0);
        expect_frame("after bad", 1'b1);
        check_counters("after bad");

        // Idle gaps and leading junk.
        apply_reset();
        word(32'h1234_5678, 3);
        body(16'h0005, 32'h0, 3);
        trailer(1'b1, 1'b1, 3);
        expect_frame("gaps", 1'b1);
        check_counters("gaps");

        // Sequence wrap and gap, consumer always ready.
        apply_reset();
        trig_ready = 1'b1;
        body(16'hFFFE, 32'h100, 0);
        trailer(1'b1, 1'b1, 0);
        expect_frame("seq fffe", 1'b1);
        check_counters("seq fffe");
        body(16'hFFFF, 32'h200, 0);
        trailer(1'b1, 1'b1, 0);
        expect_frame("seq ffff", 1'b1);
        check_counters("seq ffff");
        body(16'h0000, 32'h300, 0);
        trailer(1'b1, 1'b1, 0);
        expect_frame("seq 0000", 1'b1);
        check_counters("seq 0000");
        body(16'h0003, 32'h400, 0);
        trailer(1'b1, 1'b1, 0);
        expect_frame("seq 0003", 1'b1);
        check_counters("seq 0003");
        chk("seq gap total", seq_gap_cnt, 16'd1);
        trig_ready = 1'b0;

        // Overflow: consumer stalled while frames 7 and 8 arrive.
        apply_reset();
        body(16'h0007, 32'h700, 0);
        trailer(1'b1, 1'b1, 0);
        body(16'h0008, 32'h800, 0);
        trailer(1'b1, 1'b0, 0);
        chk("ovf held seq", trig_seq, 16'h0007);
        check_counters("ovf");
        expect_frame("ovf 7", 1'b1);

        // Consumer ready exactly on the edge frame 8 completes.
        apply_reset();
        body(16'h0007, 32'h700, 0);
        trailer(1'b1, 1'b1, 0);
        body(16'h0008, 32'h800, 0);
        expect_frame("ovf2 7", 1'b0);
        trig_ready = 1'b1;
        trailer(1'b1, 1'b1, 0);
        trig_ready = 1'b0;
        expect_frame("ovf2 8", 1'b1);
        check_counters("ovf2");

        // Channel drop mid-frame, then frame 9.
        apply_reset();
        word({16'hBE11, 16'h0020}, 0);
        word(32'h1, 0);
        word(32'h2, 0);
        chk("chan in_frame before drop", in_frame, 1'b1);
        channel_up   = 1'b0;
        rx_d         = 32'h3;
        rx_src_rdy_n = 1'b0;
        @(negedge user_clk);
        rx_src_rdy_n = 1'b1;
        channel_up   = 1'b1;
        chk("chan in_frame after drop", in_frame, 1'b0);
        body(16'h0009, 32'h900, 0);
        trailer(1'b1, 1'b1, 0);
        expect_frame("chan 9", 1'b0);
        check_counters("chan");

        // Reset while a frame is held.
        chk("pre-reset valid", trig_valid, 1'b1);
        apply_reset();
        check_reset_state("final reset");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
